pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/lock_sync_filter.sv | 44 ++++
 rtl/pll_reset_sequencer.sv | 131 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seqState_t;

    // Bit positions of the domain resets, in release order.
    localparam int DOM_MEM     = 0;
    localparam int DOM_REGS    = 1;
    localparam int DOM_CPUUNIT = 2;
    localparam int DOM_COPRO   = 3;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lock_sync_filter.sv
// Brings the asynchronous PLL LOCK into the clkin domain and qualifies it
// with a run of consecutive high cycles.
module lock_sync_filter #(
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int CNT_W              = 17
) (
    input  logic clk,
    input  logic rstn,
    input  logic hold,
    input  logic enable,
    input  logic lockAsync,
    output logic lock_sync,
    output logic lock_stable
);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);

    logic             lockMeta;
    logic [CNT_W-1:0] filtCnt;

    // Two-flop synchroniser, flushed while the PLL is held in reset so a stale LOCK is never trusted.
    always_ff @(posedge clk) begin
        if (!rstn || hold) begin
            lockMeta  <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lockMeta  <= lockAsync;
            lock_sync <= lockMeta;
        end
    end

    // Counts consecutive synchronised-high cycles; any low cycle or leaving the wait restarts it.
    always_ff @(posedge clk) begin
        if (!rstn || !enable || !lock_sync) begin
            filtCnt <= '0;
        end else if (filtCnt != FILT_LAST) begin
            filtCnt <= filtCnt + CNT_W'(1);
        end
    end

    // Asserted on the cycle whose clock edge completes the required run.
    assign lock_stable = enable && lock_sync && (filtCnt == FILT_LAST);

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock supervisor: pulses the PLL reset, waits for a filtered
// lock, then releases MEMORY, REGISTERS, CPUUNIT, COPRO resets in order.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_FILTER_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int CNT_W              = 17
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_mem_n,
    output logic       rst_regs_n,
    output logic       rst_cpuunit_n,
    output logic       rst_copro_n,
    output logic       sys_ready,
    output logic [7:0] lock_loss_count,
    output logic [7:0] retry_count
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       LAST_STAGE   = 2'(DOM_COPRO);

    seqState_t        state;
    logic [CNT_W-1:0] cycCnt;
    logic [1:0]       relStage;
    logic [3:0]       domRstN;
    logic             lockSync;
    logic             lockStable;
    logic             filtHold;
    logic             filtEnable;

    assign filtHold   = (state == PLL_RESET);
    assign filtEnable = (state == WAIT_LOCK);

    lock_sync_filter #(
        .LOCK_FILTER_CYCLES (LOCK_FILTER_CYCLES),
        .CNT_W              (CNT_W)
    ) uLockFilter (
        .clk         (clkin),
        .rstn        (rstn),
        .hold        (filtHold),
        .enable      (filtEnable),
        .lockAsync   (pll_locked),
        .lock_sync   (lockSync),
        .lock_stable (lockStable)
    );

    // Sequencer FSM; cycCnt is shared as PLL-reset length, lock timeout and release gap timer.
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state           <= PLL_RESET;
            cycCnt          <= '0;
            relStage        <= '0;
            domRstN         <= '0;
            pll_rst         <= 1'b1;
            sys_ready       <= 1'b0;
            lock_loss_count <= '0;
            retry_count     <= '0;
        end else if ((state == RELEASE || state == RUN) && !lockSync) begin
            // Lock dropped after release began: pull every domain back at once, keep the PLL running.
            state           <= WAIT_LOCK;
            cycCnt          <= '0;
            relStage        <= '0;
            domRstN         <= '0;
            sys_ready       <= 1'b0;
            lock_loss_count <= satInc8(lock_loss_count);
        end else begin
            case (state)
                PLL_RESET: begin
                    if (cycCnt == RST_LAST) begin
                        pll_rst <= 1'b0;
                        cycCnt  <= '0;
                        state   <= WAIT_LOCK;
                    end else begin
                        cycCnt <= cycCnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Filter completion takes priority over a coincident timeout.
                    if (lockStable) begin
                        domRstN[DOM_MEM] <= 1'b1;
                        relStage         <= 2'(DOM_MEM);
                        cycCnt           <= '0;
                        state            <= RELEASE;
                    end else if (cycCnt == TIMEOUT_LAST) begin
                        retry_count <= satInc8(retry_count);
                        pll_rst     <= 1'b1;
                        cycCnt      <= '0;
                        state       <= PLL_RESET;
                    end else begin
                        cycCnt <= cycCnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cycCnt == GAP_LAST) begin
                        cycCnt <= '0;
                        if (relStage == LAST_STAGE) begin
                            sys_ready <= 1'b1;
                            state     <= RUN;
                        end else begin
                            // Thermometer shift keeps the release strictly in domain order.
                            relStage <= relStage + 2'd1;
                            domRstN  <= {domRstN[2:0], 1'b1};
                        end
                    end else begin
                        cycCnt <= cycCnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    cycCnt <= cycCnt;
                end
                default: begin
                    state <= PLL_RESET;
                end
            endcase
        end
    end

    assign rst_mem_n     = domRstN[DOM_MEM];
    assign rst_regs_n    = domRstN[DOM_REGS];
    assign rst_cpuunit_n = domRstN[DOM_CPUUNIT];
    assign rst_copro_n   = domRstN[DOM_COPRO];

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

    localparam int P = 3;
    localparam int F = 4;
    localparam int G = 2;
    localparam int T = 20;

    logic       clkin = 1'b0;
    logic       rstn = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       rst_mem_n;
    logic       rst_regs_n;
    logic       rst_cpuunit_n;
    logic       rst_copro_n;
    logic       sys_ready;
    logic [7:0] lock_loss_count;
    logic [7:0] retry_count;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct packed {
        logic       pllRst;
        logic [3:0] rel;
        logic       ready;
        logic [7:0] loss;
        logic [7:0] retry;
    } exp_t;

    exp_t expQ[$];

    always #20 clkin = ~clkin;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P),
        .LOCK_FILTER_CYCLES (F),
        .STAGE_GAP          (G),
        .LOCK_TIMEOUT       (T),
        .CNT_W              (17)
    ) dut (
        .clkin           (clkin),
        .rstn            (rstn),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .rst_mem_n       (rst_mem_n),
        .rst_regs_n      (rst_regs_n),
        .rst_cpuunit_n   (rst_cpuunit_n),
        .rst_copro_n     (rst_copro_n),
        .sys_ready       (sys_ready),
        .lock_loss_count (lock_loss_count),
        .retry_count     (retry_count)
    );

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: phase + elapsed cycles; released domains follow from elapsed time.
    int mPhase = 0;   // 0 pll reset, 1 wait lock, 2 releasing, 3 running
    int mT     = 0;
    int mRun   = 0;
    int mS1    = 0;
    int mS2    = 0;
    int mLoss  = 0;
    int mRetry = 0;

    function automatic logic [3:0] thermo(input int n);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clkin) begin : refModel
        int   ls;
        int   nRel;
        exp_t e;
        ls = mS2;
        if (!rstn || mPhase == 0) begin
            mS1 = 0;
            mS2 = 0;
        end else begin
            mS2 = mS1;
            mS1 = int'(pll_locked);
        end
        if (!rstn) begin
            mPhase = 0; mT = 0; mRun = 0; mLoss = 0; mRetry = 0;
        end else begin
            case (mPhase)
                0: begin
                    mT++;
                    if (mT == P) begin mPhase = 1; mT = 0; mRun = 0; end
                end
                1: begin
                    mT++;
                    mRun = (ls != 0) ? mRun + 1 : 0;
                    if (mRun == F) begin
                        mPhase = 2; mT = 0;
                    end else if (mT == T) begin
                        mRetry = (mRetry < 255) ? mRetry + 1 : 255;
                        mPhase = 0; mT = 0;
                    end
                end
                default: begin
                    if (ls == 0) begin
                        mLoss = (mLoss < 255) ? mLoss + 1 : 255;
                        mPhase = 1; mT = 0; mRun = 0;
                    end else if (mPhase == 2) begin
                        mT++;
                        if (mT == 4 * G) mPhase = 3;
                    end
                end
            endcase
        end
        nRel = 1 + mT / G;
        if (nRel > 4) nRel = 4;
        e.pllRst = (mPhase == 0);
        e.rel    = (mPhase == 3) ? 4'hF : (mPhase == 2) ? thermo(nRel) : 4'h0;
        e.ready  = (mPhase == 3);
        e.loss   = 8'(mLoss);
        e.retry  = 8'(mRetry);
        expQ.push_back(e);
    end

    // Monitor: every clock edge the DUT presents a new registered output word.
    always @(negedge clkin) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal("pll_rst", 8'(pll_rst), 8'(e.pllRst));
            checkVal("rst_vec", 8'({rst_copro_n, rst_cpuunit_n, rst_regs_n, rst_mem_n}), 8'(e.rel));
            checkVal("sys_ready", 8'(sys_ready), 8'(e.ready));
            checkVal("lock_loss_count", lock_loss_count, e.loss);
            checkVal("retry_count", retry_count, e.retry);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
    endtask

    initial begin : stimulus
        int fallC, memC, regC, cpuC, copC, rdyC;
        rstn = 1'b0;
        pll_locked = 1'b1;
        cyc(3);

        // Power-up with lock high from the start; measure release spacing directly.
        rstn = 1'b1;
        fallC = -1; memC = -1; regC = -1; cpuC = -1; copC = -1; rdyC = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            if (fallC < 0 && !pll_rst)       fallC = c;
            if (memC  < 0 && rst_mem_n)      memC  = c;
            if (regC  < 0 && rst_regs_n)     regC  = c;
            if (cpuC  < 0 && rst_cpuunit_n)  cpuC  = c;
            if (copC  < 0 && rst_copro_n)    copC  = c;
            if (rdyC  < 0 && sys_ready)      rdyC  = c;
        end
        checkInt("pll_rst_len", fallC, P);
        checkInt("mem_after_fall", memC - fallC, 2 + F);
        checkInt("regs_after_mem", regC - memC, G);
        checkInt("cpu_after_mem", cpuC - memC, 2 * G);
        checkInt("copro_after_mem", copC - memC, 3 * G);
        checkInt("ready_after_mem", rdyC - memC, 4 * G);

        // Single-cycle glitch in the middle of the filter run.
        doReset();
        cyc(P + 3);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        cyc(30);

        // Lock never arrives: three timeouts and re-pulses.
        doReset();
        pll_locked = 1'b0;
        cyc(3 * (P + T) + 10);

        // Lock arrives, reach RUN, then drop it.
        pll_locked = 1'b1;
        cyc(25);
        pll_locked = 1'b0;
        cyc(5);
        pll_locked = 1'b1;
        cyc(25);

        // Drop between REGISTERS and CPUUNIT release, then re-lock.
        pll_locked = 1'b0;
        cyc(3);
        pll_locked = 1'b1;
        cyc(7);
        pll_locked = 1'b0;
        cyc(3);
        pll_locked = 1'b1;
        cyc(25);

        // Saturate both counters.
        doReset();
        pll_locked = 1'b0;
        cyc(300 * (P + T));
        repeat (300) begin
            pll_locked = 1'b1;
            cyc(8);
            pll_locked = 1'b0;
            cyc(3);
        end
        checkVal("retry_saturated", retry_count, 8'd255);
        checkVal("loss_saturated", lock_loss_count, 8'd255);

        // Reset pulse in the middle of RELEASE.
        pll_locked = 1'b1;
        cyc(9);
        rstn = 1'b0;
        cyc(1);
        checkVal("loss_after_reset", lock_loss_count, 8'd0);
        checkVal("retry_after_reset", retry_count, 8'd0);
        rstn = 1'b1;
        cyc(20);

        // Randomised lock behaviour with occasional reset pulses.
        repeat (60) begin
            pll_locked = 1'b1;
            cyc($urandom_range(1, 20));
            pll_locked = 1'b0;
            cyc($urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0) begin
                rstn = 1'b0;
                cyc($urandom_range(1, 2));
                rstn = 1'b1;
            end
        end
        pll_locked = 1'b1;
        cyc(30);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
